// File: rtl/mopshub_mux_pkg.sv
// Shared constants, output-stage state type and pointer helper for the mux_rr_nbit channel mux.
package mopshub_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int unsigned STATS_W = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Index of the channel after idx, wrapping to 0 after the last channel.
  function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n_ch);
    return (idx == n_ch - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_nbit.sv
// Combinational rotate-priority encoder: first set request at or after ptr, wrapping.
module rr_arbiter_nbit #(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any_gnt
);

  always_comb begin : encode
    int unsigned cand;
    cand       = 0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any_gnt    = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= N_CH) cand = cand - N_CH;
      if (!any_gnt && req[cand]) begin
        any_gnt          = 1'b1;
        gnt_onehot[cand] = 1'b1;
        gnt_idx          = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mux_rr_nbit.sv
// N_CH-to-1 handshaked mux with fixed-select or round-robin choice and a registered output stage.
// Optional grant statistics counter enabled by defining MUX_RR_STATS_EN.
module mux_rr_nbit
  import mopshub_mux_pkg::*;
#(
  parameter int unsigned N_CH   = 8,
  parameter int unsigned DATA_W = 2,
  parameter int unsigned SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel_in,
  input  logic [N_CH*DATA_W-1:0] data_in,
  input  logic [N_CH-1:0]        valid_in,
  output logic [N_CH-1:0]        ready_in,
  output logic [DATA_W-1:0]      data_out,
  output logic                   valid_out,
  input  logic                   ready_out,
  output logic [SEL_W-1:0]       grant_out
`ifdef MUX_RR_STATS_EN
  ,
  input  logic                   stats_clr,
  output logic [STATS_W-1:0]     grant_cnt
`endif
);

  out_state_e        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic              can_load_c;
  logic              xfer_c;
  logic [DATA_W-1:0] ld_data_c;
  logic [SEL_W-1:0]  ld_idx_c;

  logic [N_CH-1:0]   arb_onehot;
  logic [SEL_W-1:0]  arb_idx;
  logic              arb_any;

  rr_arbiter_nbit #(
    .N_CH  (N_CH),
    .IDX_W (SEL_W)
  ) u_arb (
    .req        (valid_in),
    .ptr        (rr_ptr_q),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx),
    .any_gnt    (arb_any)
  );

  // Accept strobe: register empty or being drained this cycle; an out-of-range sel_in matches no channel.
  always_comb begin : ready_gen
    can_load_c = 1'b0;
    ready_in   = '0;
    if (!rst) can_load_c = (state_q == ST_EMPTY) || ready_out;
    if (mode == MODE_FIXED) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (SEL_W'(k) == sel_in) ready_in[k] = can_load_c;
      end
    end else if (arb_any) begin
      ready_in = arb_onehot & {N_CH{can_load_c}};
    end
  end

  always_comb begin : next_state
    state_d   = state_q;
    data_d    = data_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    ld_data_c = '0;
    xfer_c    = |(valid_in & ready_in);
    ld_idx_c  = (mode == MODE_FIXED) ? sel_in : arb_idx;

    for (int unsigned k = 0; k < N_CH; k++) begin
      if (ready_in[k]) ld_data_c = data_in[k*DATA_W +: DATA_W];
    end

    case (state_q)
      ST_EMPTY: if (xfer_c) state_d = ST_FULL;
      ST_FULL:  if (ready_out && !xfer_c) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase

    if (xfer_c) begin
      data_d  = ld_data_c;
      grant_d = ld_idx_c;
      if (mode == MODE_RR) rr_ptr_d = SEL_W'(next_ptr(32'(arb_idx), N_CH));
    end
  end

  always_ff @(posedge clk or posedge rst) begin : regs
    if (rst) begin
      state_q  <= ST_EMPTY;
      data_q   <= '0;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign data_out  = data_q;
  assign grant_out = grant_q;
  assign valid_out = (state_q == ST_FULL);

`ifdef MUX_RR_STATS_EN
  logic [STATS_W-1:0] grant_cnt_q, grant_cnt_d;

  // Saturating transfer counter; clear wins over a same-cycle increment.
  always_comb begin : stats_next
    grant_cnt_d = grant_cnt_q;
    if (stats_clr) begin
      grant_cnt_d = '0;
    end else if (xfer_c && (grant_cnt_q != {STATS_W{1'b1}})) begin
      grant_cnt_d = grant_cnt_q + STATS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin : stats_reg
    if (rst) grant_cnt_q <= '0;
    else     grant_cnt_q <= grant_cnt_d;
  end

  assign grant_cnt = grant_cnt_q;
`endif

endmodule
